// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one outstanding request, IDLE -> ACCESS -> RESP.
// Handles byte-lane alignment for 64-bit memory words, store masking,
// and sign/zero extension of load data.
module lsu_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_addr,
  input  logic [63:0] in_wdata,
  input  logic        in_is_load,
  input  logic        in_is_store,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  input  logic [4:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_rdata,
  output logic [4:0]  out_rd,
  output logic        out_misalign,
  output logic [63:0] mem_addr,
  output logic        mem_ce,
  output logic        mem_we,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic [63:0] mem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]  state;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic        r_load;
  logic        r_store;
  logic [1:0]  r_size;
  logic        r_uns;

  logic        misalign_in;
  logic [2:0]  off;
  logic [7:0]  size_mask;
  logic [63:0] shifted;
  logic [63:0] load_ext;

  assign off = r_addr[2:0];

  // Alignment check on the incoming request
  always_comb begin
    misalign_in = 1'b0;
    case (in_size)
      2'd0: misalign_in = 1'b0;
      2'd1: misalign_in = in_addr[0];
      2'd2: misalign_in = |in_addr[1:0];
      default: misalign_in = |in_addr[2:0];
    endcase
  end

  // Byte-lane mask for the latched access size
  always_comb begin
    size_mask = 8'h00;
    case (r_size)
      2'd0: size_mask = 8'h01;
      2'd1: size_mask = 8'h03;
      2'd2: size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  end

  assign shifted = mem_rdata >> {off, 3'b000};

  // Extract and extend the addressed load field
  always_comb begin
    load_ext = '0;
    case (r_size)
      2'd0: load_ext = r_uns ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      2'd1: load_ext = r_uns ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'd2: load_ext = r_uns ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: load_ext = shifted;
    endcase
  end

  // Memory strobes are decoded from the state register, so an async reset drops them at once
  always_comb begin
    mem_addr  = {r_addr[63:3], 3'b000};
    mem_wdata = r_wdata << {off, 3'b000};
    mem_ce    = (state == ACCESS);
    mem_we    = (state == ACCESS) && r_store;
    mem_wmask = ((state == ACCESS) && r_store) ? (size_mask << off) : 8'h00;
    in_ready  = (state == IDLE);
    out_valid = (state == RESP);
  end

  // Request latch, FSM sequencing and response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_load       <= 1'b0;
      r_store      <= 1'b0;
      r_size       <= '0;
      r_uns        <= 1'b0;
      out_rdata    <= '0;
      out_rd       <= '0;
      out_misalign <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            r_addr       <= in_addr;
            r_wdata      <= in_wdata;
            r_load       <= in_is_load;
            r_store      <= in_is_store;
            r_size       <= in_size;
            r_uns        <= in_unsigned;
            out_rd       <= in_rd;
            out_misalign <= misalign_in;
            out_rdata    <= '0;
            state        <= (!misalign_in && (in_is_load || in_is_store)) ? ACCESS : RESP;
          end
        end
        ACCESS: begin
          out_rdata <= r_load ? load_ext : '0;
          state     <= RESP;
        end
        RESP: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: byte-array reference memory, directed cases plus random traffic.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_addr;
  logic [63:0] in_wdata;
  logic        in_is_load;
  logic        in_is_store;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_rdata;
  logic [4:0]  out_rd;
  logic        out_misalign;
  logic [63:0] mem_addr;
  logic        mem_ce;
  logic        mem_we;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic [63:0] mem_rdata;

  always #5 clk = ~clk;

  lsu_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_is_load(in_is_load),
    .in_is_store(in_is_store), .in_size(in_size), .in_unsigned(in_unsigned),
    .in_rd(in_rd), .out_valid(out_valid), .out_ready(out_ready),
    .out_rdata(out_rdata), .out_rd(out_rd), .out_misalign(out_misalign),
    .mem_addr(mem_addr), .mem_ce(mem_ce), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );

  localparam logic [63:0] BASE = 64'h8000_0000;

  // Memory seen by the DUT: 16 words, committed on the clock edge under the byte mask
  logic [63:0] tbmem [16];
  assign mem_rdata = tbmem[mem_addr[6:3]];

  always @(posedge clk) begin
    if (mem_ce && mem_we)
      for (int i = 0; i < 8; i++)
        if (mem_wmask[i]) tbmem[mem_addr[6:3]][8*i +: 8] <= mem_wdata[8*i +: 8];
  end

  // Reference memory as a flat byte array
  logic [7:0] refm [128];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_load(input int a, input int n, input bit uns);
    logic [63:0] v;
    logic [63:0] ones;
    v = '0;
    ones = '1;
    for (int i = 0; i < n; i++) v = v | (64'(refm[a + i]) << (8 * i));
    if (!uns && v[8 * n - 1]) v = v | (ones << (8 * n));
    return v;
  endfunction

  // One full transaction: accept, check access/latency/response, optional back-pressure, handshake
  task automatic req(input int a, input logic [63:0] wd, input bit ld, input bit st,
                     input logic [1:0] sz, input bit uns, input logic [4:0] rd, input int hold,
                     output logic [63:0] got_rdata, output logic [7:0] got_wmask,
                     output logic [63:0] got_wdata);
    int n;
    bit mis, memop;
    int lat, waited, off;
    logic [63:0] exp_rdata, exp_wdata;
    logic [7:0]  exp_wmask;
    n     = 1 << sz;
    mis   = (a % n) != 0;
    memop = !mis && (ld || st);
    off   = a % 8;
    exp_rdata = (memop && ld) ? ref_load(a, n, uns) : 64'd0;
    exp_wmask = '0;
    exp_wdata = '0;
    for (int j = 0; j < 8; j++) begin
      if (st && j >= off && j < off + n) exp_wmask[j] = 1'b1;
      if (j >= off) exp_wdata[8*j +: 8] = wd[8*(j - off) +: 8];
    end
    got_wmask = '0;
    got_wdata = '0;

    waited = 0;
    while (!in_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid    = 1'b1;
    in_addr     = BASE + 64'(a);
    in_wdata    = wd;
    in_is_load  = ld;
    in_is_store = st;
    in_size     = sz;
    in_unsigned = uns;
    in_rd       = rd;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;

    lat = 1;
    while (!out_valid && lat < 5) begin
      if (memop) begin
        chk("mem_ce", 64'(mem_ce), 64'd1);
        chk("mem_we", 64'(mem_we), 64'(st));
        chk("mem_addr", mem_addr, BASE + 64'(a - off));
        chk("mem_wmask", 64'(mem_wmask), 64'(exp_wmask));
        if (st) chk("mem_wdata", mem_wdata, exp_wdata);
        got_wmask = mem_wmask;
        got_wdata = mem_wdata;
      end else begin
        chk("mem_ce_noaccess", 64'(mem_ce), 64'd0);
      end
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), memop ? 64'd2 : 64'd1);
    if (memop && st)
      for (int i = 0; i < n; i++) refm[a + i] = wd[8*i +: 8];

    chk("out_rdata", out_rdata, exp_rdata);
    chk("out_rd", 64'(out_rd), 64'(rd));
    chk("out_misalign", 64'(out_misalign), 64'(mis));
    chk("resp_mem_ce", 64'({mem_ce, mem_we, mem_wmask}), 64'd0);
    chk("resp_in_ready", 64'(in_ready), 64'd0);
    got_rdata = out_rdata;

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_rdata", out_rdata, exp_rdata);
      chk("bp_rd", 64'(out_rd), 64'(rd));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end

    // A request offered during the handshake cycle must be ignored
    out_ready   = 1'b1;
    in_valid    = 1'b1;
    in_is_load  = 1'b0;
    in_is_store = 1'b0;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("post_hs_valid", 64'(out_valid), 64'd0);
    chk("post_hs_in_ready", 64'(in_ready), 64'd1);
  endtask

  logic [63:0] r, w, v;
  logic [7:0]  m;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_addr = '0; in_wdata = '0; in_is_load = 1'b0; in_is_store = 1'b0;
    in_size = '0; in_unsigned = 1'b0; in_rd = '0;
    #2;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_rdata", out_rdata, 64'd0);
    chk("rst_rd", 64'(out_rd), 64'd0);
    chk("rst_mis", 64'(out_misalign), 64'd0);
    chk("rst_mem", 64'({mem_ce, mem_we, mem_wmask}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Fill memory with random doublewords
    for (int k = 0; k < 16; k++)
      req(8 * k, {$urandom, $urandom}, 1'b0, 1'b1, 2'd3, 1'b0, 5'(k), 0, r, m, w);

    // Signed byte load
    req(0, 64'h0000_0000_80FF_0000, 1'b0, 1'b1, 2'd3, 1'b0, 5'd1, 0, r, m, w);
    req(3, 64'd0, 1'b1, 1'b0, 2'd0, 1'b0, 5'd2, 0, r, m, w);
    chk("lb_signed_const", r, 64'hFFFF_FFFF_FFFF_FF80);
    // Unsigned word load from upper half
    req(0, 64'h89AB_CDEF_0000_0000, 1'b0, 1'b1, 2'd3, 1'b0, 5'd3, 0, r, m, w);
    req(4, 64'd0, 1'b1, 1'b0, 2'd2, 1'b1, 5'd4, 0, r, m, w);
    chk("lwu_const", r, 64'h0000_0000_89AB_CDEF);
    // Store half into top lanes
    req(6, 64'h1234, 1'b0, 1'b1, 2'd1, 1'b0, 5'd5, 0, r, m, w);
    chk("sh_wmask_const", 64'(m), 64'hC0);
    chk("sh_wdata_const", w, 64'h1234_0000_0000_0000);
    chk("sh_rdata_const", r, 64'd0);
    // Misaligned store word
    req(2, 64'hDEAD_BEEF, 1'b0, 1'b1, 2'd2, 1'b0, 5'd6, 0, r, m, w);
    // Back-pressure on a load
    req(16, 64'd0, 1'b1, 1'b0, 2'd3, 1'b0, 5'd7, 5, r, m, w);

    // Random traffic
    for (int k = 0; k < 80; k++) begin
      int op;
      op = int'($urandom_range(0, 9));
      req(int'($urandom_range(0, 127)), {$urandom, $urandom}, op < 5, op >= 5 && op < 9,
          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
          int'($urandom_range(0, 2)), r, m, w);
    end

    // Reset pulse during the ACCESS cycle of a store double
    v = tbmem[1];
    @(negedge clk);
    in_valid = 1'b1; in_addr = BASE + 64'd8; in_wdata = ~v;
    in_is_load = 1'b0; in_is_store = 1'b1; in_size = 2'd3; in_unsigned = 1'b0; in_rd = 5'd9;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort_we_before", 64'(mem_we), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_we_async", 64'(mem_we), 64'd0);
    chk("abort_ce_async", 64'(mem_ce), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_mem_word", tbmem[1], ref_load(8, 8, 1'b1));
    chk("abort_rdata", out_rdata, 64'd0);
    chk("abort_outs", 64'({out_valid, out_rd, out_misalign, mem_wmask}), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    req(8, 64'd0, 1'b1, 1'b0, 2'd3, 1'b1, 5'd10, 0, r, m, w);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
